// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer that compacts valid fetch lanes on enqueue
// and presents the oldest NUM_SUPER entries first-word-fall-through to the decoder.
module inst_fetch_queue #(
  parameter int unsigned NUM_SUPER = 2,
  parameter int unsigned NUM_FB    = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   en,
  input  logic                                   rollback_en,
  input  logic [NUM_SUPER-1:0][63:0]             if_PC_out,
  input  logic [NUM_SUPER-1:0][63:0]             if_NPC_out,
  input  logic [NUM_SUPER-1:0][63:0]             if_target_out,
  input  logic [NUM_SUPER-1:0][31:0]             if_IR_out,
  input  logic [NUM_SUPER-1:0]                   if_valid_inst_out,
  output logic                                   fetch_en,
  input  logic [$clog2(NUM_SUPER+1)-1:0]         deq_num,
  output logic [NUM_SUPER-1:0][63:0]             out_PC,
  output logic [NUM_SUPER-1:0][63:0]             out_NPC,
  output logic [NUM_SUPER-1:0][63:0]             out_target,
  output logic [NUM_SUPER-1:0][31:0]             out_inst,
  output logic [NUM_SUPER-1:0]                   out_valid,
  output logic [$clog2(NUM_FB+1)-1:0]            count,
  output logic                                   empty,
  output logic                                   full
);

  localparam int unsigned PW = $clog2(NUM_FB);
  localparam int unsigned CW = $clog2(NUM_FB+1);

  logic [63:0]   r_pc     [NUM_FB];
  logic [63:0]   r_npc    [NUM_FB];
  logic [63:0]   r_target [NUM_FB];
  logic [31:0]   r_ir     [NUM_FB];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_off [NUM_SUPER];
  logic [CW-1:0] w_enq_cnt;
  logic [CW-1:0] w_enq_add;
  logic [CW-1:0] w_deq;
  logic          w_enq_fire;
  logic          w_deq_fire;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    w_enq_cnt = '0;
    for (int unsigned i = 0; i < NUM_SUPER; i++) begin
      w_off[i] = w_enq_cnt;
      if (if_valid_inst_out[i]) w_enq_cnt = w_enq_cnt + CW'(1);
    end
  end

  assign fetch_en   = (r_count <= CW'(NUM_FB - NUM_SUPER)) & ~rollback_en;
  assign w_enq_fire = en & fetch_en;
  assign w_deq_fire = en & ~rollback_en;
  assign w_enq_add  = w_enq_fire ? w_enq_cnt : '0;
  assign w_deq      = !w_deq_fire ? '0 :
                      (CW'(deq_num) > r_count) ? r_count : CW'(deq_num);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned k = 0; k < NUM_FB; k++) begin
        r_pc[k]     <= '0;
        r_npc[k]    <= '0;
        r_target[k] <= '0;
        r_ir[k]     <= '0;
      end
    end else if (en) begin
      if (rollback_en) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_SUPER; i++) begin
          if (w_enq_fire && if_valid_inst_out[i]) begin
            r_pc[r_tail + PW'(w_off[i])]     <= if_PC_out[i];
            r_npc[r_tail + PW'(w_off[i])]    <= if_NPC_out[i];
            r_target[r_tail + PW'(w_off[i])] <= if_target_out[i];
            r_ir[r_tail + PW'(w_off[i])]     <= if_IR_out[i];
          end
        end
        r_tail  <= r_tail + PW'(w_enq_add);
        r_head  <= r_head + PW'(w_deq);
        r_count <= r_count + w_enq_add - w_deq;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SUPER; i++) begin
      out_PC[i]     = r_pc[r_head + PW'(i)];
      out_NPC[i]    = r_npc[r_head + PW'(i)];
      out_target[i] = r_target[r_head + PW'(i)];
      out_inst[i]   = r_ir[r_head + PW'(i)];
      out_valid[i]  = r_count > CW'(i);
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(NUM_FB));

  // Decoder asking for more than is held gets clamped, but it indicates an upstream bug.
  a_deq_overrun: assert property (@(posedge clock) disable iff (reset)
    (en && !rollback_en) |-> (CW'(deq_num) <= r_count));
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    r_count <= CW'(NUM_FB));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus randomized bench for inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;
  localparam int N  = 2;
  localparam int FB = 8;

  logic                 clock = 1'b0;
  logic                 reset, en, rollback_en;
  logic [N-1:0][63:0]   if_PC_out, if_NPC_out, if_target_out;
  logic [N-1:0][31:0]   if_IR_out;
  logic [N-1:0]         if_valid_inst_out;
  logic                 fetch_en;
  logic [1:0]           deq_num;
  logic [N-1:0][63:0]   out_PC, out_NPC, out_target;
  logic [N-1:0][31:0]   out_inst;
  logic [N-1:0]         out_valid;
  logic [3:0]           count;
  logic                 empty, full;

  inst_fetch_queue #(.NUM_SUPER(N), .NUM_FB(FB)) dut (
    .clock(clock), .reset(reset), .en(en), .rollback_en(rollback_en),
    .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_target_out(if_target_out),
    .if_IR_out(if_IR_out), .if_valid_inst_out(if_valid_inst_out),
    .fetch_en(fetch_en), .deq_num(deq_num),
    .out_PC(out_PC), .out_NPC(out_NPC), .out_target(out_target),
    .out_inst(out_inst), .out_valid(out_valid),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc, npc, tgt;
    logic [31:0] ir;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    logic [N-1:0] ev;
    sz = q.size();
    for (int i = 0; i < N; i++) ev[i] = (sz > i);
    chk({tag, ".count"}, 64'(count), 64'(sz));
    chk({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    chk({tag, ".full"},  64'(full),  64'(sz == FB));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    for (int i = 0; i < N; i++) begin
      if (i < sz) begin
        chk($sformatf("%s.pc%0d", tag, i),  out_PC[i],          q[i].pc);
        chk($sformatf("%s.npc%0d", tag, i), out_NPC[i],         q[i].npc);
        chk($sformatf("%s.tgt%0d", tag, i), out_target[i],      q[i].tgt);
        chk($sformatf("%s.ir%0d", tag, i),  64'(out_inst[i]),   64'(q[i].ir));
      end
    end
  endtask

  task automatic set_lanes(input logic [N-1:0] v);
    if_valid_inst_out = v;
    for (int i = 0; i < N; i++) begin
      if_PC_out[i]     = {$urandom, $urandom};
      if_NPC_out[i]    = {$urandom, $urandom};
      if_target_out[i] = {$urandom, $urandom};
      if_IR_out[i]     = $urandom;
    end
  endtask

  // Applies current inputs for one clock: model updates, then DUT is checked after the edge.
  task automatic step(input string tag);
    ent_t e;
    int   d;
    bit   fe;
    #1;
    chk({tag, ".fetch_en"}, 64'(fetch_en), 64'(((FB - q.size()) >= N) && !rollback_en));
    if (en && !reset) begin
      if (rollback_en) q.delete();
      else begin
        fe = ((FB - q.size()) >= N);
        d  = (int'(deq_num) > q.size()) ? q.size() : int'(deq_num);
        repeat (d) void'(q.pop_front());
        if (fe) begin
          for (int i = 0; i < N; i++) begin
            if (if_valid_inst_out[i]) begin
              e.pc = if_PC_out[i]; e.npc = if_NPC_out[i];
              e.tgt = if_target_out[i]; e.ir = if_IR_out[i];
              q.push_back(e);
            end
          end
        end
      end
    end
    @(posedge clock);
    #1;
    check_state(tag);
  endtask

  initial begin
    int dmax;
    reset = 1'b1; en = 1'b0; rollback_en = 1'b0; deq_num = '0;
    set_lanes('0);
    #1;
    check_state("reset");
    chk("reset.fetch_en", 64'(fetch_en), 64'd1);
    chk("reset.pc0", out_PC[0], 64'd0);
    rollback_en = 1'b1;
    #1;
    chk("reset.fetch_en_rb", 64'(fetch_en), 64'd0);
    rollback_en = 1'b0;

    @(negedge clock);
    reset = 1'b0; en = 1'b1;

    set_lanes(2'b11); if_PC_out[0] = 64'h100; if_PC_out[1] = 64'h104;
    step("pair");
    chk("pair.pc0", out_PC[0], 64'h100);
    chk("pair.pc1", out_PC[1], 64'h104);
    chk("pair.count", 64'(count), 64'd2);
    set_lanes('0); deq_num = 2'd2; step("drain2");

    deq_num = 2'd0; set_lanes(2'b10); if_PC_out[1] = 64'h200;
    step("lane1only");
    chk("lane1only.pc0", out_PC[0], 64'h200);
    chk("lane1only.valid", 64'(out_valid), 64'b01);
    set_lanes('0); deq_num = 2'd1; step("drain1");
    deq_num = 2'd0;

    repeat (4) begin set_lanes(2'b11); step("fill"); end
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.fetch_en", 64'(fetch_en), 64'd0);
    set_lanes(2'b11); step("fifth");
    chk("fifth.count", 64'(count), 64'd8);

    set_lanes('0); deq_num = 2'd1; step("to7");
    set_lanes(2'b11); deq_num = 2'd2; step("at7");
    chk("at7.count", 64'(count), 64'd5);
    set_lanes(2'b01); deq_num = 2'd0; step("to6");
    set_lanes(2'b11); deq_num = 2'd1; step("at6");
    chk("at6.count", 64'(count), 64'd7);

    en = 1'b0; rollback_en = 1'b1; set_lanes(2'b11); deq_num = 2'd2;
    step("hold");
    chk("hold.count", 64'(count), 64'd7);
    en = 1'b1; rollback_en = 1'b0;

    for (int k = 0; k < 40; k++) begin
      set_lanes(N'($urandom));
      dmax = (q.size() < N) ? q.size() : N;
      deq_num = 2'($urandom_range(dmax, 0));
      en = ($urandom_range(7, 0) != 0);
      step($sformatf("rand%0d", k));
    end
    en = 1'b1;

    rollback_en = 1'b1; set_lanes('0); deq_num = 2'd0; step("rb_clear");
    rollback_en = 1'b0;
    repeat (3) begin set_lanes(2'b11); step("refill"); end
    set_lanes('0); deq_num = 2'd1; step("to5");
    chk("to5.count", 64'(count), 64'd5);
    rollback_en = 1'b1; set_lanes(2'b11); deq_num = 2'd2;
    step("rollback");
    chk("rollback.count", 64'(count), 64'd0);
    chk("rollback.empty", 64'(empty), 64'd1);
    rollback_en = 1'b0; deq_num = 2'd0;
    #1;
    chk("rollback.fetch_en_next", 64'(fetch_en), 64'd1);

    set_lanes(2'b11); step("burst0");
    set_lanes(2'b11); step("burst1");
    #1 reset = 1'b1;
    #1;
    q.delete();
    check_state("async_reset");
    chk("async_reset.count", 64'(count), 64'd0);
    chk("async_reset.pc0", out_PC[0], 64'd0);
    @(negedge clock);
    reset = 1'b0;
    set_lanes(2'b01); if_PC_out[0] = 64'h300;
    step("post_reset");
    chk("post_reset.pc0", out_PC[0], 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
